// File: rtl/sram_1r1w.sv
// -----------------------------------------------------------------------------
// sram_1r1w
//    Synchronous SRAM with one read port and one write port on a single clock.
//    Generic storage primitive, e.g. the per-set pseudo-LRU flag arrays.
//    Read data is registered (one-cycle latency). Same-address read/write
//    collisions follow READ_DURING_WRITE:
//       "NEW_DATA"  - read returns the data being written (bypass)
//       "OLD_DATA"  - read returns the array contents before the write
//       "DONT_CARE" - behaves exactly like OLD_DATA
//
// Parameters
//    DATA_WIDTH         bits per word (>= 1)
//    SIZE               number of words (>= 1, any value)
//    READ_DURING_WRITE  collision policy, see above
//    ADDR_WIDTH         derived address width, do not override
//
// Ports
//    clk         in   clock, all logic on posedge
//    reset       in   synchronous active-high; clears read_data only
//    read_en     in   start a read this cycle
//    read_adr    in   read address
//    read_data   out  registered read result, valid the cycle after read_en
//    write_en    in   write this cycle (also honoured while reset is high)
//    write_adr   in   write address
//    write_data  in   data to write
// -----------------------------------------------------------------------------
module sram_1r1w #(
   parameter int    DATA_WIDTH        = 32,
   parameter int    SIZE              = 64,
   parameter string READ_DURING_WRITE = "NEW_DATA",
   parameter int    ADDR_WIDTH        = (SIZE < 2) ? 1 : $clog2(SIZE)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  read_en,
   input  logic [ADDR_WIDTH-1:0] read_adr,
   output logic [DATA_WIDTH-1:0] read_data,
   input  logic                  write_en,
   input  logic [ADDR_WIDTH-1:0] write_adr,
   input  logic [DATA_WIDTH-1:0] write_data
);

   localparam bit POLICY_NEW = (READ_DURING_WRITE == "NEW_DATA");
   localparam bit POLICY_OLD = (READ_DURING_WRITE == "OLD_DATA") ||
                               (READ_DURING_WRITE == "DONT_CARE");

   generate
      if (!POLICY_NEW && !POLICY_OLD) begin : g_bad_policy
         $error("sram_1r1w: unsupported READ_DURING_WRITE value \"%s\"", READ_DURING_WRITE);
      end
   endgenerate

   // Storage starts out all-zero; reset deliberately leaves it untouched.
   logic [DATA_WIDTH-1:0] mem_reg [SIZE] = '{default: '0};

   logic [DATA_WIDTH-1:0] read_data_reg;
   logic [DATA_WIDTH-1:0] read_data_next;
   logic                  read_in_range;
   logic                  write_in_range;
   logic                  collision;

   // Address range qualification. With a power-of-two depth every address is
   // valid, so the comparators are only built for partial depths.
   generate
      if (SIZE == (1 << ADDR_WIDTH)) begin : g_full_depth
         assign read_in_range  = 1'b1;
         assign write_in_range = 1'b1;
      end else begin : g_partial_depth
         localparam logic [ADDR_WIDTH:0] SIZE_EXT = (ADDR_WIDTH + 1)'(SIZE);
         assign read_in_range  = ({1'b0, read_adr}  < SIZE_EXT);
         assign write_in_range = ({1'b0, write_adr} < SIZE_EXT);
      end
   endgenerate

   // Write port: active regardless of reset, out-of-range writes dropped.
   always_ff @(posedge clk) begin
      if (write_en && write_in_range) begin
         mem_reg[write_adr] <= write_data;
      end
   end

   // Only a write that actually lands in the array can collide with a read.
   assign collision = write_en && write_in_range && (read_adr == write_adr);

   // Read port. The array read sees the pre-write contents because the write
   // is non-blocking, which is what OLD_DATA/DONT_CARE want; NEW_DATA adds
   // an explicit write-through bypass.
   always_comb begin
      read_data_next = read_data_reg;
      if (read_en) begin
         if (!read_in_range) begin
            read_data_next = '0;
         end else if (POLICY_NEW && collision) begin
            read_data_next = write_data;
         end else begin
            read_data_next = mem_reg[read_adr];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         read_data_reg <= '0;
      end else begin
         read_data_reg <= read_data_next;
      end
   end

   assign read_data = read_data_reg;

endmodule

// File: tb/tb_sram_1r1w.sv
// -----------------------------------------------------------------------------
// tb_sram_1r1w
//    Table-driven check of three 8-bit x 4-word instances (NEW_DATA, OLD_DATA,
//    DONT_CARE) sharing one stimulus stream, followed by hand-written sequences
//    for a 5-word (partial depth) and a 1-word instance.
// -----------------------------------------------------------------------------
module tb_sram_1r1w;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Shared stimulus for the three 4-word instances
   logic       g_reset = 1'b1;
   logic       g_re    = 1'b0;
   logic [1:0] g_ra    = '0;
   logic       g_we    = 1'b0;
   logic [1:0] g_wa    = '0;
   logic [7:0] g_wd    = '0;
   logic [7:0] rd_new, rd_old, rd_dc;

   // 5-word instance
   logic       s5_reset = 1'b1;
   logic       s5_re    = 1'b0;
   logic [2:0] s5_ra    = '0;
   logic       s5_we    = 1'b0;
   logic [2:0] s5_wa    = '0;
   logic [7:0] s5_wd    = '0;
   logic [7:0] s5_rd;

   // 1-word instance
   logic       s1_reset = 1'b1;
   logic       s1_re    = 1'b0;
   logic [0:0] s1_ra    = '0;
   logic       s1_we    = 1'b0;
   logic [0:0] s1_wa    = '0;
   logic [7:0] s1_wd    = '0;
   logic [7:0] s1_rd;

   sram_1r1w #(.DATA_WIDTH(8), .SIZE(4), .READ_DURING_WRITE("NEW_DATA")) u_new (
      .clk(clk), .reset(g_reset), .read_en(g_re), .read_adr(g_ra), .read_data(rd_new),
      .write_en(g_we), .write_adr(g_wa), .write_data(g_wd));

   sram_1r1w #(.DATA_WIDTH(8), .SIZE(4), .READ_DURING_WRITE("OLD_DATA")) u_old (
      .clk(clk), .reset(g_reset), .read_en(g_re), .read_adr(g_ra), .read_data(rd_old),
      .write_en(g_we), .write_adr(g_wa), .write_data(g_wd));

   sram_1r1w #(.DATA_WIDTH(8), .SIZE(4), .READ_DURING_WRITE("DONT_CARE")) u_dc (
      .clk(clk), .reset(g_reset), .read_en(g_re), .read_adr(g_ra), .read_data(rd_dc),
      .write_en(g_we), .write_adr(g_wa), .write_data(g_wd));

   sram_1r1w #(.DATA_WIDTH(8), .SIZE(5), .READ_DURING_WRITE("NEW_DATA")) u_s5 (
      .clk(clk), .reset(s5_reset), .read_en(s5_re), .read_adr(s5_ra), .read_data(s5_rd),
      .write_en(s5_we), .write_adr(s5_wa), .write_data(s5_wd));

   sram_1r1w #(.DATA_WIDTH(8), .SIZE(1), .READ_DURING_WRITE("NEW_DATA")) u_s1 (
      .clk(clk), .reset(s1_reset), .read_en(s1_re), .read_adr(s1_ra), .read_data(s1_rd),
      .write_en(s1_we), .write_adr(s1_wa), .write_data(s1_wd));

   typedef struct {
      logic       rst;
      logic       re;
      logic [1:0] ra;
      logic       we;
      logic [1:0] wa;
      logic [7:0] wd;
      logic [7:0] exp_new;   // expected read_data after the edge, NEW_DATA
      logic [7:0] exp_old;   // expected read_data after the edge, OLD_DATA/DONT_CARE
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rst, input logic re, input logic [1:0] ra,
                               input logic we, input logic [1:0] wa, input logic [7:0] wd,
                               input logic [7:0] exp_new, input logic [7:0] exp_old);
      vec_t v;
      v.rst = rst; v.re = re; v.ra = ra; v.we = we; v.wa = wa; v.wd = wd;
      v.exp_new = exp_new; v.exp_old = exp_old;
      return v;
   endfunction

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: read_data=%h expected=%h", name, got, exp);
      end else begin
         $display("ok   %s: read_data=%h", name, got);
      end
   endtask

   // One clock for the 5-word instance; outputs sampled 1 ns after the edge.
   task automatic s5_cycle(input logic re, input logic [2:0] ra,
                           input logic we, input logic [2:0] wa, input logic [7:0] wd);
      s5_re = re; s5_ra = ra; s5_we = we; s5_wa = wa; s5_wd = wd;
      @(posedge clk);
      #1;
   endtask

   task automatic s1_cycle(input logic re, input logic [0:0] ra,
                           input logic we, input logic [0:0] wa, input logic [7:0] wd);
      s1_re = re; s1_ra = ra; s1_we = we; s1_wa = wa; s1_wd = wd;
      @(posedge clk);
      #1;
   endtask

   initial begin
      //                 rst   re    ra    we    wa    wd     new    old
      // reset overrides a read; then reads of a never-written array
      vecs.push_back(mk(1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00));
      vecs.push_back(mk(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00));
      vecs.push_back(mk(1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00));
      vecs.push_back(mk(1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00));
      vecs.push_back(mk(1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00));
      vecs.push_back(mk(1'b0, 1'b1, 2'd3, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00));
      // write during reset lands; concurrent read is overridden by reset
      vecs.push_back(mk(1'b1, 1'b1, 2'd0, 1'b1, 2'd0, 8'h3C, 8'h00, 8'h00));
      vecs.push_back(mk(1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 8'h00, 8'h3C, 8'h3C));
      // write A5@2 with no read: output holds
      vecs.push_back(mk(1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 8'hA5, 8'h3C, 8'h3C));
      vecs.push_back(mk(1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 8'h00, 8'hA5, 8'hA5));
      vecs.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 8'h00, 8'hA5, 8'hA5));
      // mem[1]=11, then collision write 22@1 + read @1
      vecs.push_back(mk(1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 8'h11, 8'hA5, 8'hA5));
      vecs.push_back(mk(1'b0, 1'b1, 2'd1, 1'b1, 2'd1, 8'h22, 8'h22, 8'h11));
      vecs.push_back(mk(1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 8'h00, 8'h22, 8'h22));
      // different-address read and write are independent
      vecs.push_back(mk(1'b0, 1'b1, 2'd2, 1'b1, 2'd3, 8'h77, 8'hA5, 8'hA5));
      vecs.push_back(mk(1'b0, 1'b1, 2'd3, 1'b0, 2'd0, 8'h00, 8'h77, 8'h77));
      // back-to-back writes to @0, second collides with a read
      vecs.push_back(mk(1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 8'h01, 8'h77, 8'h77));
      vecs.push_back(mk(1'b0, 1'b1, 2'd0, 1'b1, 2'd0, 8'h02, 8'h02, 8'h01));
      vecs.push_back(mk(1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 8'h00, 8'h02, 8'h02));
      // reset clears read_data but not the array
      vecs.push_back(mk(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00));
      vecs.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00));
      vecs.push_back(mk(1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 8'h00, 8'hA5, 8'hA5));

      foreach (vecs[i]) begin
         g_reset = vecs[i].rst;
         g_re    = vecs[i].re;
         g_ra    = vecs[i].ra;
         g_we    = vecs[i].we;
         g_wa    = vecs[i].wa;
         g_wd    = vecs[i].wd;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d new_data", i), rd_new, vecs[i].exp_new);
         check($sformatf("vec%0d old_data", i), rd_old, vecs[i].exp_old);
         check($sformatf("vec%0d dont_care", i), rd_dc, vecs[i].exp_old);
      end
      g_re = 1'b0;
      g_we = 1'b0;

      // ---- SIZE=5: out-of-range accesses ----
      s5_cycle(1'b1, 3'd0, 1'b0, 3'd0, 8'h00);
      check("s5 reset", s5_rd, 8'h00);
      s5_reset = 1'b0;
      for (int a = 0; a < 5; a++) begin
         s5_cycle(1'b0, 3'd0, 1'b1, 3'(a), 8'(8'h10 * a + 8'h01));
      end
      s5_cycle(1'b0, 3'd0, 1'b1, 3'd7, 8'hFF);
      s5_cycle(1'b1, 3'd4, 1'b0, 3'd0, 8'h00);
      check("s5 read@4", s5_rd, 8'h41);
      s5_cycle(1'b1, 3'd7, 1'b0, 3'd0, 8'h00);
      check("s5 read@7", s5_rd, 8'h00);
      s5_cycle(1'b1, 3'd3, 1'b0, 3'd0, 8'h00);
      check("s5 read@3", s5_rd, 8'h31);
      s5_cycle(1'b1, 3'd6, 1'b1, 3'd6, 8'hEE);
      check("s5 oor collision@6", s5_rd, 8'h00);
      for (int a = 0; a < 5; a++) begin
         s5_cycle(1'b1, 3'(a), 1'b0, 3'd0, 8'h00);
         check($sformatf("s5 unchanged@%0d", a), s5_rd, 8'(8'h10 * a + 8'h01));
      end

      // ---- SIZE=1: single-word round trip ----
      s1_cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      check("s1 reset", s1_rd, 8'h00);
      s1_reset = 1'b0;
      s1_cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h5A);
      s1_cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      check("s1 read@0", s1_rd, 8'h5A);
      s1_cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'hC3);
      check("s1 collision@0", s1_rd, 8'hC3);
      s1_cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h99);
      s1_cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      check("s1 read@0 after oor write", s1_rd, 8'hC3);
      s1_cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      check("s1 read@1", s1_rd, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
